// File: rtl/snowbro2_cen_pkg.sv
// ============================================================================
// Module      : snowbro2_cen_pkg
// Description : Shared FSM state type and default constants for the CEN monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snowbro2_cen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } cen_state_t;

    localparam int c_DEF_WINDOW  = 96000;
    localparam int c_DEF_EXPECT  = 2700;
    localparam int c_DEF_TOL     = 2;
    localparam int c_DEF_GAP_LIM = 40;
    localparam int c_DEF_CNT_W   = 20;

    // Lower acceptance bound, clamped so a tolerance larger than the target cannot go negative.
    function automatic logic [31:0] f_lo_bound(input int expect_cnt, input int tol);
        return (expect_cnt > tol) ? 32'(expect_cnt - tol) : 32'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snowbro2_cen_win_cnt.sv
// ============================================================================
// Module      : snowbro2_cen_win_cnt
// Description : Measurement window counter with terminal-count flag on WINDOW-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snowbro2_cen_win_cnt
    import snowbro2_cen_pkg::*;
#(
    parameter int WINDOW = c_DEF_WINDOW
) (
    input  logic CLK96,
    input  logic RESET_N,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    localparam int               c_W    = $clog2(WINDOW);
    localparam logic [c_W-1:0]   c_LAST = c_W'(WINDOW - 1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge CLK96 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + c_W'(1);
        end
    end

    assign o_tc = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/snowbro2_cen_monitor.sv
// ============================================================================
// Module      : snowbro2_cen_monitor
// Description : Counts CEN pulses over fixed CLK96 windows and flags lock/error.
//               Optional gap checker enabled by SNOWBRO2_CEN_MON_GAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snowbro2_cen_monitor
    import snowbro2_cen_pkg::*;
#(
    parameter int WINDOW  = c_DEF_WINDOW,
    parameter int EXPECT  = c_DEF_EXPECT,
    parameter int TOL     = c_DEF_TOL,
    parameter int CNT_W   = c_DEF_CNT_W
`ifdef SNOWBRO2_CEN_MON_GAP_EN
   ,parameter int GAP_LIM = c_DEF_GAP_LIM
`endif
) (
    input  logic             CLK96,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             CEN,
    output logic [CNT_W-1:0] COUNT,
    output logic             VALID,
    output logic             ERR,
    output logic             LOCKED
`ifdef SNOWBRO2_CEN_MON_GAP_EN
   ,output logic [CNT_W-1:0] MAX_GAP,
    output logic             GAP_ERR
`endif
);

    localparam logic [31:0] c_LO = f_lo_bound(EXPECT, TOL);
    localparam logic [31:0] c_HI = 32'(EXPECT + TOL);

    cen_state_t       r_state;
    cen_state_t       w_next;
    logic             w_tc;
    logic             w_keep;
    logic             w_done;
    logic             w_err;
    logic [CNT_W-1:0] w_pulse_nxt;
    logic [31:0]      w_cnt32;
    logic [CNT_W-1:0] r_pulse;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_err;
    logic             r_locked;

    snowbro2_cen_win_cnt #(
        .WINDOW (WINDOW)
    ) u_win_cnt (
        .CLK96   (CLK96),
        .RESET_N (RESET_N),
        .i_clear (r_state != ST_MEASURE),
        .i_inc   (r_state == ST_MEASURE),
        .o_tc    (w_tc)
    );

    always_ff @(posedge CLK96 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    w_next = EN ? ST_MEASURE : ST_IDLE;
            ST_MEASURE: begin
                if (!EN) begin
                    w_next = ST_IDLE;
                end else if (w_tc) begin
                    w_next = ST_REPORT;
                end
            end
            ST_REPORT:  w_next = EN ? ST_MEASURE : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Pulse count including this cycle's CEN; latched straight into COUNT on the final cycle.
    always_comb begin
        w_keep      = (r_state == ST_MEASURE) && (w_next == ST_MEASURE);
        w_done      = (r_state == ST_MEASURE) && (w_next == ST_REPORT);
        w_pulse_nxt = (CEN && (r_pulse != '1)) ? r_pulse + CNT_W'(1) : r_pulse;
        w_cnt32     = 32'(w_pulse_nxt);
        w_err       = (w_cnt32 < c_LO) || (w_cnt32 > c_HI);
    end

    always_ff @(posedge CLK96 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pulse  <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_pulse <= w_keep ? w_pulse_nxt : '0;
            r_valid <= w_done;
            if (w_done) begin
                r_count  <= w_pulse_nxt;
                r_err    <= w_err;
                r_locked <= !w_err;
            end
        end
    end

    assign COUNT  = r_count;
    assign VALID  = r_valid;
    assign ERR    = r_err;
    assign LOCKED = r_locked;

`ifdef SNOWBRO2_CEN_MON_GAP_EN
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_gap_max;
    logic [CNT_W-1:0] r_max_gap_out;
    logic             r_gap_err;
    logic [CNT_W-1:0] w_gap_nxt;
    logic [CNT_W-1:0] w_gap_max_nxt;

    always_comb begin
        w_gap_nxt     = CEN ? '0 : ((r_gap == '1) ? r_gap : r_gap + CNT_W'(1));
        w_gap_max_nxt = (w_gap_nxt > r_gap_max) ? w_gap_nxt : r_gap_max;
    end

    always_ff @(posedge CLK96 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gap         <= '0;
            r_gap_max     <= '0;
            r_max_gap_out <= '0;
            r_gap_err     <= 1'b0;
        end else begin
            r_gap     <= w_keep ? w_gap_nxt : '0;
            r_gap_max <= w_keep ? w_gap_max_nxt : '0;
            if (w_done) begin
                r_max_gap_out <= w_gap_max_nxt;
                r_gap_err     <= 32'(w_gap_max_nxt) > 32'(GAP_LIM);
            end
        end
    end

    assign MAX_GAP = r_max_gap_out;
    assign GAP_ERR = r_gap_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snowbro2_cen_monitor.sv
// ============================================================================
// Module      : tb_snowbro2_cen_monitor
// Description : Self-checking bench for snowbro2_cen_monitor (three parameter sets).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snowbro2_cen_monitor;

    localparam int c_WIN = 320;

    logic clk;
    logic rst_n;
    logic en;
    logic cen;

    logic [7:0]  count_a, count_b;
    logic [19:0] count_c;
    logic        valid_a, valid_b, valid_c;
    logic        err_a, err_b, err_c;
    logic        lock_a, lock_b, lock_c;
`ifdef SNOWBRO2_CEN_MON_GAP_EN
    logic [7:0]  gap_a, gap_b;
    logic [19:0] gap_c;
    logic        gerr_a, gerr_b, gerr_c;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // A: nominal 9/320 target, B: off-by-one target, C: wide counter with clamped low bound.
    snowbro2_cen_monitor #(
        .WINDOW(c_WIN), .EXPECT(9), .TOL(0), .CNT_W(8)
`ifdef SNOWBRO2_CEN_MON_GAP_EN
       ,.GAP_LIM(40)
`endif
    ) u_dut_a (
        .CLK96(clk), .RESET_N(rst_n), .EN(en), .CEN(cen),
        .COUNT(count_a), .VALID(valid_a), .ERR(err_a), .LOCKED(lock_a)
`ifdef SNOWBRO2_CEN_MON_GAP_EN
       ,.MAX_GAP(gap_a), .GAP_ERR(gerr_a)
`endif
    );

    snowbro2_cen_monitor #(
        .WINDOW(c_WIN), .EXPECT(10), .TOL(0), .CNT_W(8)
`ifdef SNOWBRO2_CEN_MON_GAP_EN
       ,.GAP_LIM(40)
`endif
    ) u_dut_b (
        .CLK96(clk), .RESET_N(rst_n), .EN(en), .CEN(cen),
        .COUNT(count_b), .VALID(valid_b), .ERR(err_b), .LOCKED(lock_b)
`ifdef SNOWBRO2_CEN_MON_GAP_EN
       ,.MAX_GAP(gap_b), .GAP_ERR(gerr_b)
`endif
    );

    snowbro2_cen_monitor #(
        .WINDOW(c_WIN), .EXPECT(1), .TOL(3), .CNT_W(20)
`ifdef SNOWBRO2_CEN_MON_GAP_EN
       ,.GAP_LIM(40)
`endif
    ) u_dut_c (
        .CLK96(clk), .RESET_N(rst_n), .EN(en), .CEN(cen),
        .COUNT(count_c), .VALID(valid_c), .ERR(err_c), .LOCKED(lock_c)
`ifdef SNOWBRO2_CEN_MON_GAP_EN
       ,.MAX_GAP(gap_c), .GAP_ERR(gerr_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit out_of_band(input int c, input int e, input int t);
        int lo;
        lo = (e > t) ? e - t : 0;
        return (c < lo) || (c > e + t);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: windows of c_WIN enabled cycles, then one report cycle.
    // ------------------------------------------------------------------
    bit m_run, m_rep, m_valid;
    int m_pos, m_pul, m_gap, m_gmax;
    int m_cnt_a, m_cnt_c, m_gap_a;
    bit m_err_a, m_err_b, m_err_c, m_lock_a, m_lock_b, m_lock_c, m_gerr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0; m_rep <= 0; m_valid <= 0;
            m_pos <= 0; m_pul <= 0; m_gap <= 0; m_gmax <= 0;
            m_cnt_a <= 0; m_cnt_c <= 0; m_gap_a <= 0; m_gerr <= 0;
            m_err_a <= 0; m_err_b <= 0; m_err_c <= 0;
            m_lock_a <= 0; m_lock_b <= 0; m_lock_c <= 0;
        end else begin : step
            int pos, pul, gap, gmax, ca;
            bit run, rep;
            pos = m_pos; pul = m_pul; gap = m_gap; gmax = m_gmax;
            run = m_run; rep = 0;
            if (m_rep || !m_run) begin
                run = en;
                if (en) begin pos = 0; pul = 0; gap = 0; gmax = 0; end
            end else if (!en) begin
                run = 0;
            end else begin
                if (cen) begin pul++; gap = 0; end else gap++;
                if (gap > gmax) gmax = gap;
                pos++;
                if (pos == c_WIN) begin run = 0; rep = 1; end
            end
            m_pos <= pos; m_pul <= pul; m_gap <= gap; m_gmax <= gmax;
            m_run <= run; m_rep <= rep; m_valid <= rep;
            if (rep) begin
                ca = sat(pul, 255);
                m_cnt_a  <= ca;
                m_err_a  <= out_of_band(ca, 9, 0);
                m_lock_a <= !out_of_band(ca, 9, 0);
                m_err_b  <= out_of_band(ca, 10, 0);
                m_lock_b <= !out_of_band(ca, 10, 0);
                m_cnt_c  <= pul;
                m_err_c  <= out_of_band(pul, 1, 3);
                m_lock_c <= !out_of_band(pul, 1, 3);
                m_gap_a  <= sat(gmax, 255);
                m_gerr   <= sat(gmax, 255) > 40;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_valid_a", valid_a, m_valid);
        chk("model_valid_b", valid_b, m_valid);
        chk("model_valid_c", valid_c, m_valid);
        chk("model_count_a", count_a, m_cnt_a);
        chk("model_err_a",   err_a,   m_err_a);
        chk("model_lock_a",  lock_a,  m_lock_a);
        chk("model_err_b",   err_b,   m_err_b);
        chk("model_lock_b",  lock_b,  m_lock_b);
        chk("model_count_c", count_c, m_cnt_c);
        chk("model_err_c",   err_c,   m_err_c);
        chk("model_lock_c",  lock_c,  m_lock_c);
`ifdef SNOWBRO2_CEN_MON_GAP_EN
        chk("model_max_gap_a", gap_a,  m_gap_a);
        chk("model_gap_err_a", gerr_a, m_gerr);
`endif
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    typedef enum int {M_FRAC, M_HIGH, M_NONE, M_SKIP, M_FIRST, M_ALT} cen_mode_t;

    typedef struct {
        cen_mode_t mode;
        int        arg;
        int        cnt_a;
        bit        err_a;
        bit        err_b;
        int        cnt_c;
        bit        err_c;
        bit        gerr;
    } vec_t;

    function automatic bit frac_pulse(input int k);
        return ((k + 1) * 9) / c_WIN != (k * 9) / c_WIN;
    endfunction

    function automatic bit scen_cen(input cen_mode_t mode, input int arg, input int k);
        case (mode)
            M_FRAC:  return frac_pulse(k);
            M_HIGH:  return 1'b1;
            M_NONE:  return 1'b0;
            M_SKIP:  return frac_pulse(k) && (((k + 1) * 9) / c_WIN != arg);
            M_FIRST: return k < arg;
            M_ALT:   return (k % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From idle: enable, feed one full window, leave the bench sitting in the report cycle.
    task automatic run_window(input cen_mode_t mode, input int arg);
        en = 1'b1; cen = 1'b0;
        tick();
        for (int k = 0; k < c_WIN; k++) begin
            cen = scen_cen(mode, arg, k);
            tick();
        end
        cen = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        bit early;
        int acc;

        vecs[0] = '{M_FRAC,  0,   9, 0, 1,   9, 1, 0};
        vecs[1] = '{M_HIGH,  0, 255, 1, 1, 320, 1, 0};
        vecs[2] = '{M_NONE,  0,   0, 1, 1,   0, 0, 1};
        vecs[3] = '{M_SKIP,  4,   8, 1, 1,   8, 1, 1};
        vecs[4] = '{M_FIRST, 4,   4, 1, 1,   4, 0, 1};
        vecs[5] = '{M_FIRST, 5,   5, 1, 1,   5, 1, 1};
        vecs[6] = '{M_FIRST, 10, 10, 1, 0,  10, 1, 1};
        vecs[7] = '{M_ALT,   0, 160, 1, 1, 160, 1, 0};

        rst_n = 1'b0; en = 1'b0; cen = 1'b0;
        #23;
        chk("reset_count_a", count_a, 0);
        chk("reset_valid_a", valid_a, 0);
        chk("reset_err_a",   err_a,   0);
        chk("reset_lock_a",  lock_a,  0);
        rst_n = 1'b1;
        tick(); tick();

        // Table-driven windows
        foreach (vecs[i]) begin
            en = 1'b0; tick();
            run_window(vecs[i].mode, vecs[i].arg);
            chk($sformatf("vec%0d_valid_a", i), valid_a, 1);
            chk($sformatf("vec%0d_count_a", i), count_a, vecs[i].cnt_a);
            chk($sformatf("vec%0d_err_a", i),   err_a,   vecs[i].err_a);
            chk($sformatf("vec%0d_lock_a", i),  lock_a,  !vecs[i].err_a);
            chk($sformatf("vec%0d_err_b", i),   err_b,   vecs[i].err_b);
            chk($sformatf("vec%0d_lock_b", i),  lock_b,  !vecs[i].err_b);
            chk($sformatf("vec%0d_count_c", i), count_c, vecs[i].cnt_c);
            chk($sformatf("vec%0d_err_c", i),   err_c,   vecs[i].err_c);
`ifdef SNOWBRO2_CEN_MON_GAP_EN
            chk($sformatf("vec%0d_gap_err_a", i), gerr_a, vecs[i].gerr);
`endif
            en = 1'b0; tick();
        end

        // Back-to-back windows, then EN dropped 100 cycles into the next one
        run_window(M_FRAC, 0);
        tick();
        for (int k = 0; k < 100; k++) begin
            cen = frac_pulse(k);
            tick();
        end
        en = 1'b0; cen = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (valid_a) early = 1'b1;
        end
        chk("drop_no_valid", early, 0);
        chk("drop_count_held", count_a, 9);
        chk("drop_lock_held", lock_a, 1);

        // Re-enable: VALID must arrive in the 321st cycle after the IDLE->MEASURE edge
        en = 1'b1;
        tick();
        early = 1'b0;
        for (int k = 0; k < c_WIN; k++) begin
            if (valid_a) early = 1'b1;
            cen = frac_pulse(k);
            tick();
        end
        cen = 1'b0;
        chk("reen_no_early_valid", early, 0);
        chk("reen_valid_at_321", valid_a, 1);
        chk("reen_count", count_a, 9);

        // Randomised traffic around the nominal rate with occasional EN drops
        acc = 0;
        for (int k = 0; k < 4000; k++) begin
            acc += 9;
            en  = ($urandom_range(0, 299) != 0);
            cen = (acc >= c_WIN) ^ ($urandom_range(0, 149) == 0);
            if (acc >= c_WIN) acc -= c_WIN;
            tick();
        end

        // Asynchronous reset mid-window after a good window
        en = 1'b0; cen = 1'b0; tick();
        run_window(M_FRAC, 0);
        tick();
        for (int k = 0; k < 50; k++) begin
            cen = frac_pulse(k);
            tick();
        end
        chk("pre_reset_count", count_a, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count_a", count_a, 0);
        chk("async_valid_a", valid_a, 0);
        chk("async_err_a",   err_a,   0);
        chk("async_lock_a",  lock_a,  0);
        chk("async_err_b",   err_b,   0);
        chk("async_count_c", count_c, 0);
`ifdef SNOWBRO2_CEN_MON_GAP_EN
        chk("async_max_gap", gap_a,  0);
        chk("async_gap_err", gerr_a, 0);
`endif
        en = 1'b0; cen = 1'b0;
        tick(); tick();
        #3;
        rst_n = 1'b1;
        tick(); tick();
        run_window(M_FRAC, 0);
        chk("post_reset_valid", valid_a, 1);
        chk("post_reset_count", count_a, 9);
        chk("post_reset_lock",  lock_a,  1);
        en = 1'b0; tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snowbro2_cen_monitor.md
SNOWBRO2_CEN_MONITOR -- requirements
Module: snowbro2_cen_monitor

Interface
REQ-001 Parameter WINDOW, default 96000, measurement window length in CLK96 cycles (1 ms at 96 MHz); SHALL be >= 2.
REQ-002 Parameter EXPECT, default 2700, expected CEN pulse count per window.
REQ-003 Parameter TOL, default 2, allowed absolute deviation from EXPECT.
REQ-004 Parameter CNT_W, default 20, width of the pulse counter and the COUNT output.
REQ-005 Parameter GAP_LIM, default 40, maximum allowed CLK96 cycles between consecutive CEN pulses; used only with the macro.
REQ-006 CLK96 input 1: sole clock, 96 MHz; all logic on its rising edge.
REQ-007 RESET_N input 1: asynchronous active-low reset.
REQ-008 EN input 1: high runs back-to-back windows; low returns the monitor to idle.
REQ-009 CEN input 1: clock-enable strobe under test, one CLK96 cycle wide per pulse.
REQ-010 COUNT output CNT_W: pulse count of the last completed window.
REQ-011 VALID output 1: one-cycle strobe when COUNT, ERR and LOCKED update.
REQ-012 ERR output 1: last completed window outside EXPECT±TOL.
REQ-013 LOCKED output 1: last completed window within EXPECT±TOL.
REQ-014 MAX_GAP output CNT_W and GAP_ERR output 1: present only with the macro.

Function
REQ-015 FSM states IDLE, MEASURE, REPORT; after reset the FSM SHALL be in IDLE.
REQ-016 IDLE: EN=1 -> MEASURE on the next edge, clearing the window and pulse counters; EN=0 -> stay in IDLE.
REQ-017 MEASURE: each cycle increments the window counter; CEN=1 in that cycle increments the pulse counter, which saturates at 2^CNT_W-1.
REQ-018 When the window counter equals WINDOW-1 and EN=1, the FSM SHALL go to REPORT; the CEN of that final cycle SHALL be counted.
REQ-019 A window therefore spans exactly WINDOW MEASURE cycles.
REQ-020 REPORT, one cycle:
 - VALID=1;
 - COUNT = final pulse count;
 - ERR = (COUNT < EXPECT-TOL) or (COUNT > EXPECT+TOL), computed with EXPECT-TOL clamped at 0;
 - LOCKED = not ERR.
REQ-021 REPORT is a dead cycle: CEN in it SHALL NOT be counted. Next state is MEASURE with counters cleared if EN=1, otherwise IDLE.
REQ-022 EN falling in MEASURE -> IDLE on the next edge; the partial window SHALL be discarded, no VALID, and COUNT/ERR/LOCKED hold.
REQ-023 COUNT, ERR and LOCKED SHALL change only in REPORT. VALID SHALL be 0 in all other states.

Reset
REQ-024 RESET_N low SHALL force, asynchronously:
 - state IDLE;
 - all counters 0;
 - COUNT=0, VALID=0, ERR=0, LOCKED=0;
 - MAX_GAP=0, GAP_ERR=0.
REQ-025 Reset asserted mid-window SHALL discard the window. Operation SHALL resume only on an EN=1 cycle after release.

Configuration
REQ-026 Macro SNOWBRO2_CEN_MON_GAP_EN.
REQ-027 Defined:
 - a gap counter SHALL count cycles since the last CEN within the window;
 - it SHALL restart at 0 on each CEN;
 - it SHALL restart at window start;
 - the largest value per window SHALL be latched to MAX_GAP in REPORT;
 - GAP_ERR = MAX_GAP > GAP_LIM.
REQ-028 Undefined: MAX_GAP and GAP_ERR ports and the gap logic SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-029 Package snowbro2_cen_pkg SHALL hold the FSM state enum and the default constants 96000, 2700, 2 and 40.
REQ-030 Sub-module snowbro2_cen_win_cnt SHALL implement the window counter with a terminal-count flag, instantiated once.

Verification
REQ-031 Test parameters WINDOW=320, EXPECT=9, TOL=0, n/m = 9/320 fractional CEN source, EN=1 -> every VALID gives COUNT=9, LOCKED=1, ERR=0.
REQ-032 Same source with TOL=0, EXPECT=10 -> COUNT=9, ERR=1, LOCKED=0.
REQ-033 CEN held high constantly, WINDOW=320, CNT_W=8 -> COUNT=255 (saturated), ERR=1.
REQ-034 EN dropped at cycle 100 of a window -> no VALID, prior COUNT held. EN re-raised -> first VALID exactly 321 cycles after the IDLE->MEASURE edge.
REQ-035 RESET_N pulsed low mid-window -> all outputs 0 immediately, with no clock edge needed.
REQ-036 With SNOWBRO2_CEN_MON_GAP_EN, GAP_LIM=40, and one CEN suppressed (gap of about 70) -> GAP_ERR=1 at the next VALID. Without the macro the bench SHALL compile without the gap ports.
